mem_arbiter: RTL and testbench

Arbitrates the single physical memory port between the instruction-fetch requester (mem1, IF stage) and the data requester (mem2, MEM stage) of the pipelined LC-3b core. The arbiter latches the winning request, drives the physical memory until it returns pmem_resp, and routes the response back to the requester that owns the transaction. The block sits between the two L1 caches and physical memory.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single physical memory port between the instruction-fetch
// requester (i_*) and the data requester (d_*). A request seen in IDLE is
// granted and latched. The latched transaction drives pmem_* until pmem_resp.
// The completion is then routed back, in the same cycle, to the owning side.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_read, i_address        instruction read request (held until i_resp)
//   i_resp, i_rdata          instruction completion pulse and data
//   d_read, d_write,         data read/write request (held until d_resp);
//   d_address, d_wdata       read+write together is treated as a write
//   d_resp, d_rdata          data completion pulse and data
//   pmem_read, pmem_write,   physical memory strobes, address and write line
//   pmem_address, pmem_wdata
//   pmem_resp, pmem_rdata    physical memory completion pulse and read line
//   arb_busy                 high whenever a transaction is being served
//
// Build option:
//   ARB_RR_EN  defined   -> a tie goes to the side that was not granted last
//              undefined -> fixed priority; the data side always wins a tie
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic              arb_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [LINE_W-1:0] r_wdata, w_wdata_next;
  logic              r_op_wr, w_op_wr_next;
  // 1 = data side was granted last; reset value favours I on the first tie.
  logic              r_last_d, w_last_d_next;

  logic w_d_req;
  logic w_grant_d;

  assign w_d_req = d_read | d_write;

`ifdef ARB_RR_EN
  // On a tie the data side wins only if instruction side was served last.
  assign w_grant_d = w_d_req & (~i_read | ~r_last_d);
`else
  assign w_grant_d = w_d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_op_wr  <= 1'b0;
      r_last_d <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_addr   <= w_addr_next;
      r_wdata  <= w_wdata_next;
      r_op_wr  <= w_op_wr_next;
      r_last_d <= w_last_d_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_addr_next   = r_addr;
    w_wdata_next  = r_wdata;
    w_op_wr_next  = r_op_wr;
    w_last_d_next = r_last_d;
    i_resp        = 1'b0;
    i_rdata       = '0;
    d_resp        = 1'b0;
    d_rdata       = '0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_address  = '0;
    pmem_wdata    = '0;

    case (r_state)
      IDLE: begin
        if (w_d_req | i_read) begin
          w_state_next = w_grant_d ? SERVE_D : SERVE_I;
          w_addr_next  = w_grant_d ? d_address : i_address;
          // Write data is captured only for writes so reads present zero.
          w_op_wr_next = w_grant_d & d_write;
          w_wdata_next = (w_grant_d & d_write) ? d_wdata : '0;
        end
      end
      SERVE_I, SERVE_D: begin
        // Everything comes from the latched copy, so a requester changing
        // its inputs mid-transaction cannot disturb the memory.
        pmem_read    = ~r_op_wr;
        pmem_write   = r_op_wr;
        pmem_address = r_addr;
        pmem_wdata   = r_op_wr ? r_wdata : '0;
        if (pmem_resp) begin
          w_state_next = IDLE;
          if (r_state == SERVE_D) begin
            d_resp        = 1'b1;
            d_rdata       = pmem_rdata;
            w_last_d_next = 1'b1;
          end else begin
            i_resp        = 1'b1;
            i_rdata       = pmem_rdata;
            w_last_d_next = 1'b0;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign arb_busy = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. A transaction-level reference model tracks
// the outstanding grant and is compared with the DUT outputs on every falling
// clock edge. Directed sequences add literal expectations that pin the model.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic          i_resp;
  logic [LW-1:0] i_rdata;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic          d_resp;
  logic [LW-1:0] d_rdata;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_resp = 1'b0;
  logic [LW-1:0] pmem_rdata = '0;
  logic          arb_busy;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_i = 0;
  int n_d = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One outstanding transaction at most: who owns it, what it does, where.
  bit            m_valid = 1'b0;
  bit            m_is_d = 1'b0;
  bit            m_wr = 1'b0;
  bit            m_last_d = 1'b1;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0;
  bit            m_take_d;

  function automatic bit winner_is_d(input bit ireq, input bit dreq, input bit last_d);
    if (!dreq) return 1'b0;
    if (!ireq) return 1'b1;
    return RR ? !last_d : 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_is_d   <= 1'b0;
      m_wr     <= 1'b0;
      m_last_d <= 1'b1;
      m_addr   <= '0;
      m_wdata  <= '0;
    end else if (!m_valid) begin
      if (i_read || d_read || d_write) begin
        m_take_d = winner_is_d(i_read, d_read || d_write, m_last_d);
        m_valid <= 1'b1;
        m_is_d  <= m_take_d;
        m_wr    <= m_take_d && d_write;
        m_addr  <= m_take_d ? d_address : i_address;
        m_wdata <= (m_take_d && d_write) ? d_wdata : '0;
      end
    end else if (pmem_resp) begin
      m_valid  <= 1'b0;
      m_last_d <= m_is_d;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("arb_busy", arb_busy, m_valid);
      check("pmem_read", pmem_read, m_valid && !m_wr);
      check("pmem_write", pmem_write, m_valid && m_wr);
      if (m_valid) begin
        check("pmem_address", pmem_address, m_addr);
        check("pmem_wdata", pmem_wdata, m_wdata);
      end
      check("i_resp", i_resp, m_valid && !m_is_d && pmem_resp);
      check("d_resp", d_resp, m_valid && m_is_d && pmem_resp);
      check("i_rdata", i_rdata, (m_valid && !m_is_d && pmem_resp) ? pmem_rdata : '0);
      check("d_rdata", d_rdata, (m_valid && m_is_d && pmem_resp) ? pmem_rdata : '0);
      if (i_resp) n_i++;
      if (d_resp) n_d++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [LW-1:0] a5_line;
  bit            w1_d;
  int            nd0;

  initial begin
    a5_line = {16{8'hA5}};
    w1_d    = RR ? 1'b0 : 1'b1;

    // Reset state
    tick();
    check("rst_busy", arb_busy, 1'b0);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Single instruction read, 4-cycle memory
    i_read = 1'b1; i_address = 16'h0040;
    tick();
    check("t1_pmem_read", pmem_read, 1'b1);
    check("t1_addr", pmem_address, 16'h0040);
    tick();
    tick();
    pmem_resp = 1'b1; pmem_rdata = a5_line;
    #1;
    check("t1_i_resp", i_resp, 1'b1);
    check("t1_i_rdata", i_rdata, a5_line);
    check("t1_d_resp", d_resp, 1'b0);
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0; i_read = 1'b0;
    #1;
    check("t1_idle_after", arb_busy, 1'b0);

    // Data write with address changing mid-transaction
    nd0 = n_d;
    d_write = 1'b1; d_address = 16'h1000; d_wdata = 128'h1234;
    tick();
    check("t2_pmem_write", pmem_write, 1'b1);
    check("t2_addr0", pmem_address, 16'h1000);
    check("t2_wdata0", pmem_wdata, 128'h1234);
    d_address = 16'hFFFF;
    tick();
    check("t2_addr1", pmem_address, 16'h1000);
    tick();
    check("t2_wdata1", pmem_wdata, 128'h1234);
    pmem_resp = 1'b1;
    #1;
    check("t2_d_resp", d_resp, 1'b1);
    tick();
    pmem_resp = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    tick();
    check("t2_d_resp_count", n_d - nd0, 1);

    // Two back-to-back ties (winner re-requests in the idle cycle)
    i_read = 1'b1; i_address = 16'h0100;
    d_read = 1'b1; d_address = 16'h0200;
    tick();
    check("tie1_addr", pmem_address, w1_d ? 16'h0200 : 16'h0100);
    tick();
    pmem_resp = 1'b1; pmem_rdata = 128'h11;
    #1;
    check("tie1_resp", {i_resp, d_resp}, w1_d ? 2'b01 : 2'b10);
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    tick();
    check("tie2_addr", pmem_address, 16'h0200);
    pmem_resp = 1'b1; pmem_rdata = 128'h22;
    #1;
    check("tie2_resp", {i_resp, d_resp}, 2'b01);
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0; d_read = 1'b0;
    tick();
    check("tie_loser_addr", pmem_address, 16'h0100);
    pmem_resp = 1'b1; pmem_rdata = 128'h33;
    #1;
    check("tie_loser_resp", {i_resp, d_resp}, 2'b10);
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0; i_read = 1'b0;
    tick();

    // Asynchronous reset in the middle of a data write
    d_write = 1'b1; d_address = 16'h2000; d_wdata = 128'hBEEF;
    tick();
    tick();
    check("rst_mid_write_before", pmem_write, 1'b1);
    #2;
    rst = 1'b1; pmem_resp = 1'b1;
    #1;
    check("rst_mid_pmem_write", pmem_write, 1'b0);
    check("rst_mid_busy", arb_busy, 1'b0);
    check("rst_mid_d_resp", d_resp, 1'b0);
    tick();
    rst = 1'b0; pmem_resp = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    tick();
    i_read = 1'b1; i_address = 16'h0300;
    tick();
    check("post_rst_read", pmem_read, 1'b1);
    check("post_rst_addr", pmem_address, 16'h0300);
    pmem_resp = 1'b1; pmem_rdata = 128'h44;
    #1;
    check("post_rst_i_resp", i_resp, 1'b1);
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0; i_read = 1'b0;
    tick();

    // Stray pmem_resp while idle
    pmem_resp = 1'b1; pmem_rdata = 128'h55;
    #1;
    check("idle_resp", {i_resp, d_resp}, 2'b00);
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    #1;
    check("idle_resp_busy", arb_busy, 1'b0);

    // Read and write together act as a write
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h0400; d_wdata = 128'h5A5A;
    tick();
    check("rw_pmem_write", pmem_write, 1'b1);
    check("rw_pmem_read", pmem_read, 1'b0);
    check("rw_wdata", pmem_wdata, 128'h5A5A);
    tick();
    pmem_resp = 1'b1;
    #1;
    check("rw_d_resp", d_resp, 1'b1);
    tick();
    pmem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
